vc_grant_scheduler: RTL

Packet-locking round-robin scheduler for the router's shared output stage. Picks one of N input FIFOs and holds the grant until that requester's tail flit transfers. Stalls on downstream back-pressure and releases an abandoned grant after a programmable idle timeout. Sits between the input FIFOs' valid/tail flags and the routing-computation stage, and drives the per-FIFO ready selection.

---
 rtl/vc_grant_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vc_grant_scheduler.sv
// Packet-locking round-robin grant scheduler for a shared router output stage.
// Holds a grant until the tail flit moves, stalls on back-pressure, and frees an abandoned grant after an idle timeout.
module vc_grant_scheduler #(
  parameter int N       = 5,
  parameter int TIMEOUT = 15,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] tail,
  input  logic         out_stall,
  output logic [N-1:0] grant,
  output logic         xfer,
  output logic         busy,
  output logic         timeout_evt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] IDLE_LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  idle_cnt_q, idle_cnt_d;
  logic           timeout_evt_q, timeout_evt_d;

  logic [PW-1:0]  g_idx;
  logic [PW-1:0]  g_next;
  logic [N-1:0]   others;
  logic           holder_req;
  logic           tail_xfer;

  // First set bit of v, scanning upward from p with wrap to 0.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input logic [PW-1:0] p);
    logic [N-1:0]  oh;
    logic          found;
    logic [PW-1:0] idx;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(p) + i) % N);
      if (!found && v[idx]) begin
        oh[idx] = 1'b1;
        found   = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [PW-1:0] oh_index(input logic [N-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  assign g_idx      = oh_index(grant_q);
  assign g_next     = (g_idx == PW'(N - 1)) ? '0 : g_idx + 1'b1;
  assign others     = req & ~grant_q;
  assign holder_req = |(grant_q & req);
  assign xfer       = holder_req & ~out_stall;
  assign tail_xfer  = xfer & |(grant_q & tail);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    idle_cnt_d    = idle_cnt_q;
    timeout_evt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d    = rr_pick(req, ptr_q);
          idle_cnt_d = '0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (tail_xfer) begin
          ptr_d      = g_next;
          idle_cnt_d = '0;
          if (|others) begin
            grant_d = rr_pick(others, g_next);
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (!holder_req) begin
          // Holder went quiet; stalled cycles with the holder still requesting never count.
          if (idle_cnt_q == IDLE_LIMIT) begin
            grant_d       = '0;
            ptr_d         = g_next;
            idle_cnt_d    = '0;
            timeout_evt_d = 1'b1;
            state_d       = IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      ptr_q         <= '0;
      idle_cnt_q    <= '0;
      timeout_evt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      idle_cnt_q    <= idle_cnt_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q == HOLD);
  assign timeout_evt = timeout_evt_q;

endmodule
